// File: rtl/switch_accumulator_pkg.sv
// Shared constants and types for the switch accumulator: register map, CTRL bit
// positions and the per-button press FSM state.
package switch_accumulator_pkg;

    localparam logic [1:0] ADDR_ACC    = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_SWITCH = 2'd3;

    localparam int unsigned CTRL_MODE_BIT  = 0;
    localparam int unsigned CTRL_SAT_BIT   = 1;
    localparam int unsigned STATUS_OVF_BIT = 0;

    typedef enum logic {
        IDLE_UP,
        DOWN
    } btn_state_e;

endpackage

// File: rtl/button_debounce.sv
// Active-low key conditioner: 2-flop synchroniser, stable-sample debounce counter
// and a press FSM that emits one event per debounced press.
module button_debounce
    import switch_accumulator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_ni,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    btn_state_e      state_q, state_d;
    logic            press_q, press_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        // Count consecutive samples that disagree with the accepted level.
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        state_d = state_q;
        press_d = 1'b0;
        unique case (state_q)
            IDLE_UP: begin
                if (!level_q) begin
                    state_d = DOWN;
                    press_d = 1'b1;
                end
            end
            DOWN: begin
                if (level_q) begin
                    state_d = IDLE_UP;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE_UP;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_ni;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/switch_accumulator.sv
// Switch/LED accumulator with clear key, add/load mode, wrap or saturate overflow
// and an Avalon-MM slave exposing ACC, CTRL, STATUS and the synchronised switches.
module switch_accumulator
    import switch_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH            = 8,
    parameter int unsigned DEBOUNCE_CYCLES  = 500000,
    parameter bit          SATURATE_DEFAULT = 1'b0
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] switch_wire_export,
    input  logic             accumulate_button_export,
    input  logic             clear_button_export,
    output logic [WIDTH-1:0] led_wire_export,
    output logic             overflow_export,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata
);

    logic [WIDTH-1:0] sw_sync1_q, sw_sync2_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             mode_q, mode_d;
    logic             sat_q, sat_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             accum_evt, clear_evt;
    logic             acc_wr, ctrl_wr, status_wr;
    logic [WIDTH:0]   sum;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_accum_btn (
        .clk_i  (clk_clk),
        .rst_i  (reset_reset),
        .btn_ni (accumulate_button_export),
        .level_o(),
        .press_o(accum_evt)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear_btn (
        .clk_i  (clk_clk),
        .rst_i  (reset_reset),
        .btn_ni (clear_button_export),
        .level_o(),
        .press_o(clear_evt)
    );

    always_comb begin
        acc_wr    = avs_write && (avs_address == ADDR_ACC);
        ctrl_wr   = avs_write && (avs_address == ADDR_CTRL);
        status_wr = avs_write && (avs_address == ADDR_STATUS);
        sum       = {1'b0, acc_q} + {1'b0, sw_sync2_q};

        acc_d  = acc_q;
        mode_d = mode_q;
        sat_d  = sat_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;

        if (ctrl_wr) begin
            mode_d = avs_writedata[CTRL_MODE_BIT];
            sat_d  = avs_writedata[CTRL_SAT_BIT];
        end
        if (status_wr && avs_writedata[STATUS_OVF_BIT]) begin
            ovf_d = 1'b0;
        end

        // Lowest priority first; later assignments override ACC/ovf but not count.
        if (accum_evt) begin
            cnt_d = cnt_q + 16'd1;
            if (mode_q) begin
                acc_d = sw_sync2_q;
            end else begin
                acc_d = (sum[WIDTH] && sat_q) ? '1 : sum[WIDTH-1:0];
                if (sum[WIDTH]) begin
                    ovf_d = 1'b1;
                end
            end
        end
        if (acc_wr) begin
            acc_d = avs_writedata[WIDTH-1:0];
        end
        if (clear_evt) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end

        rdata_d = rdata_q;
        if (avs_read) begin
            rdata_d = '0;
            unique case (avs_address)
                ADDR_ACC:    rdata_d[WIDTH-1:0] = acc_q;
                ADDR_CTRL: begin
                    rdata_d[CTRL_MODE_BIT] = mode_q;
                    rdata_d[CTRL_SAT_BIT]  = sat_q;
                end
                ADDR_STATUS: begin
                    rdata_d[STATUS_OVF_BIT] = ovf_q;
                    rdata_d[31:16]          = cnt_q;
                end
                ADDR_SWITCH: rdata_d[WIDTH-1:0] = sw_sync2_q;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            acc_q      <= '0;
            mode_q     <= 1'b0;
            sat_q      <= SATURATE_DEFAULT;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            rdata_q    <= '0;
        end else begin
            sw_sync1_q <= switch_wire_export;
            sw_sync2_q <= sw_sync1_q;
            acc_q      <= acc_d;
            mode_q     <= mode_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
        end
    end

    assign led_wire_export = acc_q;
    assign overflow_export = ovf_q;
    assign avs_readdata    = rdata_q;

endmodule
